// File: rtl/multiword_add_sequencer_pkg.sv
// Shared definitions for the multi-word add sequencer: FSM state
// encoding and the word-index width helper.
package multiword_add_sequencer_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } seq_state_t;

    // Width of the word index; at least one bit so a counter always exists.
    function automatic int idx_width(input int numwords);
        return (numwords <= 1) ? 1 : $clog2(numwords);
    endfunction

endpackage

// File: rtl/ripple_carry_adder.sv
// Plain NUMBITS-wide ripple-carry adder, one full-adder cell per bit.
module ripple_carry_adder #(
    parameter int NUMBITS = 16
) (
    input  logic [NUMBITS-1:0] a,
    input  logic [NUMBITS-1:0] b,
    input  logic               cin,
    output logic [NUMBITS-1:0] s,
    output logic               cout
);

    logic [NUMBITS:0] c;

    assign c[0] = cin;

    // Per-bit full-adder cells chained through c[].
    for (genvar i = 0; i < NUMBITS; i++) begin : g_bit
        assign s[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i+1] = (a[i] & b[i]) | (a[i] & c[i]) | (b[i] & c[i]);
    end

    assign cout = c[NUMBITS];

endmodule

// File: rtl/multiword_add_sequencer.sv
// Multi-precision adder controller: adds two NUMWORDS x NUMBITS operands
// through one shared NUMBITS-wide adder, LSW first, one word per cycle,
// with the carry held in a register between word steps.
// Optional macro SEQ_SUBTRACT_EN adds an op_sub port for A-B.
module multiword_add_sequencer
    import multiword_add_sequencer_pkg::*;
#(
    parameter int NUMBITS  = 16,
    parameter int NUMWORDS = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic [NUMBITS*NUMWORDS-1:0]  a_in,
    input  logic [NUMBITS*NUMWORDS-1:0]  b_in,
    input  logic                         carryin,
`ifdef SEQ_SUBTRACT_EN
    input  logic                         op_sub,
`endif
    output logic                         busy,
    output logic                         done,
    output logic [NUMBITS*NUMWORDS-1:0]  sum,
    output logic                         carryout
);

    localparam int IW = idx_width(NUMWORDS);
    localparam logic [IW-1:0] LAST = IW'(NUMWORDS - 1);

    seq_state_t                        state;
    logic [IW-1:0]                     idx;
    logic                              cy;
    logic [NUMWORDS-1:0][NUMBITS-1:0]  a_q;
    logic [NUMWORDS-1:0][NUMBITS-1:0]  b_q;
    logic [NUMWORDS-1:0][NUMBITS-1:0]  sum_q;

    logic [NUMBITS-1:0]                add_s;
    logic                              add_co;
    logic                              sub_req;

`ifdef SEQ_SUBTRACT_EN
    assign sub_req = op_sub;
`else
    assign sub_req = 1'b0;
`endif

    // Shared datapath: current word of each operand plus the carry register.
    ripple_carry_adder #(
        .NUMBITS (NUMBITS)
    ) u_rca (
        .a    (a_q[idx]),
        .b    (b_q[idx]),
        .cin  (cy),
        .s    (add_s),
        .cout (add_co)
    );

    assign sum = sum_q;

    // Sequencer FSM: accept in IDLE, one word per RUN cycle, one-cycle DONE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            idx      <= '0;
            cy       <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            sum_q    <= '0;
            carryout <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_q      <= a_in;
                        // Subtraction is A + ~B + 1, so only the latch changes.
                        b_q      <= sub_req ? ~b_in : b_in;
                        cy       <= sub_req ? 1'b1 : carryin;
                        sum_q    <= '0;
                        carryout <= 1'b0;
                        idx      <= '0;
                        busy     <= 1'b1;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    sum_q[idx] <= add_s;
                    cy         <= add_co;
                    if (idx == LAST) begin
                        carryout <= add_co;
                        done     <= 1'b1;
                        state    <= DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_multiword_add_sequencer.sv
// Self-checking bench for multiword_add_sequencer (NUMBITS=16, NUMWORDS=4).
// Results are predicted when an operation is accepted and compared by a
// monitor whenever done pulses.
module tb_multiword_add_sequencer;

    localparam int NB = 16;
    localparam int NW = 4;
    localparam int W  = NB * NW;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] a_in, b_in;
    logic         carryin;
    logic         op_sub;
    logic         busy, done, carryout;
    logic [W-1:0] sum;

    multiword_add_sequencer #(.NUMBITS(NB), .NUMWORDS(NW)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .a_in     (a_in),
        .b_in     (b_in),
        .carryin  (carryin),
`ifdef SEQ_SUBTRACT_EN
        .op_sub   (op_sub),
`endif
        .busy     (busy),
        .done     (done),
        .sum      (sum),
        .carryout (carryout)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [W-1:0] s;
        logic         c;
    } res_t;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic         sub;
        logic [W-1:0] exp_s;
        logic         exp_c;
    } vec_t;

    res_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    logic done_d = 1'b0;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model, independent of the word-serial structure.
    function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic cin, input logic sub);
        logic [W:0] full;
        res_t r;
        full = {1'b0, a} + {1'b0, (sub ? ~b : b)} + {{W{1'b0}}, (sub ? 1'b1 : cin)};
        r.s = full[W-1:0];
        r.c = full[W];
        return r;
    endfunction

    // Scoreboard monitor: every done pulse must match the oldest prediction.
    always @(negedge clk) begin
        if (!rst) begin
            if (done) begin
                if (done_d) begin
                    checks++;
                    errors++;
                    $display("FAIL done_width: got 2+ cycle pulse expected 1");
                end
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: got done with empty scoreboard expected none");
                end else begin
                    res_t e;
                    e = exp_q.pop_front();
                    chk("sum", sum, e.s);
                    chk("carryout", {{(W-1){1'b0}}, carryout}, {{(W-1){1'b0}}, e.c});
                end
            end
            done_d <= done;
        end else begin
            done_d <= 1'b0;
        end
    end

    // Drive one request at a negedge; returns once the following edge accepts it.
    task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic cin, input logic sub, input logic predict);
        @(negedge clk);
        a_in = a; b_in = b; carryin = cin; op_sub = sub; start = 1'b1;
        @(posedge clk);
        if (predict) exp_q.push_back(model(a, b, cin, sub));
        #1;
        start = 1'b0;
        // Operands are free to change once the request is taken.
        a_in = {$urandom, $urandom}; b_in = {$urandom, $urandom};
        carryin = $urandom_range(0, 1); op_sub = $urandom_range(0, 1);
    endtask

    // Count negedges until done, bounded.
    task automatic wait_done(output int cyc);
        cyc = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (done) begin
                cyc = k;
                break;
            end
        end
        if (cyc == 0) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: got no done in 40 cycles expected done");
        end
    endtask

    vec_t vecs[$];
    int   cyc, gap;

    initial begin
        rst = 1'b1; start = 1'b0; a_in = '0; b_in = '0; carryin = 1'b0; op_sub = 1'b0;

        // Directed table, expectations written out by hand.
        vecs.push_back('{64'h0000_0000_0000_FFFF, 64'h1, 1'b0, 1'b0, 64'h0000_0000_0001_0000, 1'b0});
        vecs.push_back('{64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 1'b0, 64'h0, 1'b1});
        vecs.push_back('{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1});
        vecs.push_back('{64'h0000_FFFF_0000_FFFF, 64'h0000_0001_0000_0001, 1'b1, 1'b0, 64'h0001_0000_0001_0001, 1'b0});
        vecs.push_back('{64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 1'b0, 64'h0, 1'b1});
        vecs.push_back('{64'h1234_5678_9ABC_DEF0, 64'h1111_1111_1111_1111, 1'b0, 1'b0, 64'h2345_6789_ABCD_F001, 1'b0});
`ifdef SEQ_SUBTRACT_EN
        vecs.push_back('{64'd5, 64'd7, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0});
        vecs.push_back('{64'd7, 64'd5, 1'b0, 1'b1, 64'd2, 1'b1});
`endif

        // Reset held two cycles.
        repeat (2) @(posedge clk);
        #1;
        chk("reset_busy", {63'd0, busy}, 64'd0);
        chk("reset_done", {63'd0, done}, 64'd0);
        chk("reset_sum", sum, 64'd0);
        chk("reset_carryout", {63'd0, carryout}, 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // Table: predicted result queued, plus hand-written value and latency.
        foreach (vecs[i]) begin
            launch(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub, 1'b1);
            chk("busy_after_accept", {63'd0, busy}, 64'd1);
            wait_done(cyc);
            chk("latency", 64'(cyc), 64'd5);
            chk("table_sum", sum, vecs[i].exp_s);
            chk("table_carryout", {63'd0, carryout}, {63'd0, vecs[i].exp_c});
            @(negedge clk);
            chk("output_hold", sum, vecs[i].exp_s);
            chk("busy_idle", {63'd0, busy}, 64'd0);
        end

        // Random operands against the model.
        for (int i = 0; i < 6; i++) begin
            launch({$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom_range(0, 1)),
`ifdef SEQ_SUBTRACT_EN
                   1'($urandom_range(0, 1)),
`else
                   1'b0,
`endif
                   1'b1);
            wait_done(cyc);
        end

        // Start re-pulsed while busy must be ignored.
        launch(64'd3, 64'd4, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        a_in = 64'd100; b_in = 64'd100; carryin = 1'b0; op_sub = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(cyc);
        chk("ignored_start_sum", sum, 64'd7);
        launch(64'd100, 64'd100, 1'b0, 1'b0, 1'b1);
        wait_done(cyc);
        chk("next_start_sum", sum, 64'd200);

        // Asynchronous reset mid-run (index 2): immediate clear, no done.
        launch(64'h0009_0009_0009_0009, 64'h0009_0009_0009_0009, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_sum", sum, 64'd0);
        chk("async_rst_busy", {63'd0, busy}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (8) @(negedge clk);
        chk("no_done_after_abort", {63'd0, done}, 64'd0);
        launch(64'd1, 64'd1, 1'b0, 1'b0, 1'b1);
        wait_done(cyc);
        chk("after_abort_sum", sum, 64'd2);

        // Start held high: back-to-back ops, NUMWORDS+2 cycles apart.
        @(negedge clk);
        exp_q.push_back(model(64'h0001_0000_0000_FFFF, 64'h2, 1'b1, 1'b0));
        exp_q.push_back(model(64'h0001_0000_0000_FFFF, 64'h2, 1'b1, 1'b0));
        a_in = 64'h0001_0000_0000_FFFF; b_in = 64'h2; carryin = 1'b1; op_sub = 1'b0; start = 1'b1;
        wait_done(cyc);
        wait_done(gap);
        start = 1'b0;
        chk("throughput_gap", 64'(gap), 64'd6);
        repeat (10) @(negedge clk);
        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/multiword_add_sequencer.md
Name: multiword_add_sequencer

Overview:
- Multi-precision adder controller. Adds two NUMWORDS×NUMBITS operands by time-multiplexing one NUMBITS-wide ripple-carry adder, one word per cycle, least-significant word first.
- Carry is held in a register between word steps.
- Sits between a requesting unit (start/done handshake) and the shared adder datapath. Allows wide additions without a wide combinational carry chain.

Parameters:
- NUMBITS, 16, width of one word slice and of the internal adder.
- NUMWORDS, 4, number of word slices per operand; must be ≥ 2.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request; accepted only in IDLE.
- a_in  input  NUMBITS*NUMWORDS  operand A; sampled when start is accepted.
- b_in  input  NUMBITS*NUMWORDS  operand B; sampled when start is accepted.
- carryin  input  1  initial carry; sampled when start is accepted.
- busy  output  1  high in RUN and DONE.
- done  output  1  single-cycle pulse when sum and carryout are valid.
- sum  output  NUMBITS*NUMWORDS  registered result.
- carryout  output  1  carry out of the most-significant word.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values: state=IDLE, word index=0, carry register=0, operand registers=0, sum=0, carryout=0, busy=0, done=0.
- IDLE:
  - busy=0.
  - start=1 latches a_in, b_in and carryin (into the carry register), clears sum and carryout to 0, sets index=0, and moves to RUN.
- RUN:
  - Each cycle, the adder sees word[index] of A and B plus the carry register.
  - At the clock edge, sum word[index] ← adder result, carry register ← adder carryout, index ← index+1.
  - At index=NUMWORDS-1, carryout ← adder carryout and the state moves to DONE.
  - Index never wraps; it is reset to 0 on acceptance.
- DONE: done=1 for exactly one cycle, then IDLE.
- Latency: start accepted at edge t → done high during the cycle after edge t+NUMWORDS. That is NUMWORDS+1 cycles start-to-done.
- Output hold: sum and carryout stay stable after done until the next accepted start.
- start while busy=1 (RUN or DONE): ignored, no queuing. Operand inputs may change freely once start is accepted.
- start held high continuously: a new operation is accepted on every IDLE cycle, giving a throughput of one op per NUMWORDS+2 cycles.
- rst mid-operation: immediate abort to reset values; no done pulse; partial sum discarded.
- Arithmetic is unsigned modulo 2^(NUMBITS*NUMWORDS). carryout is the true carry of the full-width sum.
- Only the registered carry crosses word boundaries; there is no combinational path from carryin to sum/carryout.

Optional Feature:
- Macro: SEQ_SUBTRACT_EN.
- Defined:
  - Adds input port op_sub (1 bit), sampled with start.
  - op_sub=1: B is latched bit-inverted and the carry register is initialised to 1, regardless of carryin. Result is A−B modulo 2^W.
  - carryout=1 means no borrow (A≥B).
  - op_sub=0 behaves exactly as without the macro.
- Undefined: no op_sub port; addition only.

Decomposition:
- Shared package holds:
  - state encoding constants: IDLE=2'd0, RUN=2'd1, DONE=2'd2;
  - a width-helper function computing index width as clog2(NUMWORDS).
- One sub-module: the team's existing ripple_carry_adder, instantiated once with NUMBITS=NUMBITS.
- The sequencer contains only the FSM, index counter, operand/sum registers and carry register.

Test Plan (NUMBITS=16, NUMWORDS=4):
- Reset asserted for 2 cycles → busy=0, done=0, sum=0, carryout=0. Reset asserted asynchronously between edges → outputs clear immediately.
- A=0x0000_0000_0000_FFFF, B=0x1, carryin=0, start pulse → done 5 cycles later; sum=0x0000_0000_0001_0000, carryout=0.
- A=0xFFFF_FFFF_FFFF_FFFF, B=0x0, carryin=1 → sum=0, carryout=1 (carry propagates through all four word steps).
- Op1 A=3, B=4; start re-pulsed with A=100, B=100 two cycles after acceptance → ignored; done gives sum=7; next IDLE start gives sum=200.
- rst pulsed while index=2 in RUN → IDLE, sum=0, no done pulse; a following start with A=1, B=1 → sum=2.
- SEQ_SUBTRACT_EN: A=5, B=7, op_sub=1 → sum=0xFFFF_FFFF_FFFF_FFFE, carryout=0. A=7, B=5 → sum=2, carryout=1.
